// File: rtl/cmd_wb_master.sv
// cmd_wb_master: executes one decoded command as a classic Wishbone cycle.
// Reads are streamed back as four response bytes, most significant first.
// The upstream buffer gets a one-cycle acknowledge once the command is done.
module cmd_wb_master #(
   parameter int          TIMEOUT     = 1023,
   parameter logic [31:0] ERR_DATA    = 32'hFFFFFFFF,
   parameter              WB_CLK_TYPE = "NONE"
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [21:0] cmd_address_i,
   input  logic        cmd_rd_i,
   input  logic [31:0] cmd_data_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ack_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [21:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic [7:0]  resp_tdata,
   output logic        resp_tvalid,
   input  logic        resp_tready,
   output logic        resp_tlast,
   output logic        buserr_o,
   output logic        timeout_o
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_BUS      = 3'd1;
   localparam logic [2:0] S_RESP_3   = 3'd2;
   localparam logic [2:0] S_RESP_2   = 3'd3;
   localparam logic [2:0] S_RESP_1   = 3'd4;
   localparam logic [2:0] S_RESP_0   = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;
   localparam logic [2:0] S_WAIT_CLR = 3'd7;

   // Counter wide enough to hold TIMEOUT; a disabled timeout still gets one bit.
   localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TERM_CNT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   // The clock-type tag is pure metadata for CDC constraint scripts; this
   // named scope makes a non-default tag visible in the elaborated hierarchy.
   if (WB_CLK_TYPE != "NONE") begin : g_custom_clk_type
   end

   logic [2:0]    state_r;
   logic [2:0]    state_s;
   logic [31:0]   data_r;
   logic [31:0]   data_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic          buserr_s;
   logic          timeout_s;
   logic          beat_s;

   // Pick the response byte that belongs to a given response state.
   function automatic logic [7:0] resp_byte(input logic [2:0] st, input logic [31:0] d);
      logic [7:0] b;
      case (st)
         S_RESP_3: b = d[31:24];
         S_RESP_2: b = d[23:16];
         S_RESP_1: b = d[15:8];
         S_RESP_0: b = d[7:0];
         default:  b = 8'h00;
      endcase
      return b;
   endfunction

   assign wb_sel_o = 4'hF;
   assign beat_s   = resp_tvalid && resp_tready;

   // Next-state, latched read data, bus-cycle counter and termination pulses.
   always_comb begin
      state_s   = state_r;
      data_s    = data_r;
      cnt_s     = cnt_r;
      buserr_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (cmd_valid_i) begin
               state_s = S_BUS;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_BUS: begin
            // Error beats ack, and either beats the timeout on the terminal cycle.
            if (wb_err_i) begin
               buserr_s = 1'b1;
               cnt_s    = {CW{1'b0}};
               data_s   = ERR_DATA;
               state_s  = wb_we_o ? S_DONE : S_RESP_3;
            end else if (wb_ack_i) begin
               cnt_s    = {CW{1'b0}};
               data_s   = wb_dat_i;
               state_s  = wb_we_o ? S_DONE : S_RESP_3;
            end else if ((TIMEOUT != 0) && (cnt_r == TERM_CNT)) begin
               timeout_s = 1'b1;
               cnt_s     = {CW{1'b0}};
               data_s    = ERR_DATA;
               state_s   = wb_we_o ? S_DONE : S_RESP_3;
            end else if (cnt_r != CNT_MAX) begin
               cnt_s = cnt_r + CW'(1);
            end else begin
               cnt_s = cnt_r;
            end
         end
         S_RESP_3: begin
            if (beat_s) state_s = S_RESP_2; else state_s = S_RESP_3;
         end
         S_RESP_2: begin
            if (beat_s) state_s = S_RESP_1; else state_s = S_RESP_2;
         end
         S_RESP_1: begin
            if (beat_s) state_s = S_RESP_0; else state_s = S_RESP_1;
         end
         S_RESP_0: begin
            if (beat_s) state_s = S_DONE; else state_s = S_RESP_0;
         end
         S_DONE: begin
            state_s = S_WAIT_CLR;
         end
         S_WAIT_CLR: begin
            // Wait for upstream to drop valid so the same command is not re-run.
            if (!cmd_valid_i) state_s = S_IDLE; else state_s = S_WAIT_CLR;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State plus all outputs, registered from the next-state view.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r     <= S_IDLE;
         data_r      <= 32'h0000_0000;
         cnt_r       <= {CW{1'b0}};
         cmd_ack_o   <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= 22'h00_0000;
         wb_dat_o    <= 32'h0000_0000;
         resp_tdata  <= 8'h00;
         resp_tvalid <= 1'b0;
         resp_tlast  <= 1'b0;
         buserr_o    <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state_r <= state_s;
         data_r  <= data_s;
         cnt_r   <= cnt_s;
         if ((state_r == S_IDLE) && cmd_valid_i) begin
            wb_adr_o <= cmd_address_i;
            wb_dat_o <= cmd_data_i;
            wb_we_o  <= !cmd_rd_i;
         end else begin
            wb_adr_o <= wb_adr_o;
            wb_dat_o <= wb_dat_o;
            wb_we_o  <= wb_we_o;
         end
         wb_cyc_o    <= (state_s == S_BUS);
         wb_stb_o    <= (state_s == S_BUS);
         resp_tvalid <= (state_s == S_RESP_3) || (state_s == S_RESP_2) ||
                        (state_s == S_RESP_1) || (state_s == S_RESP_0);
         resp_tdata  <= resp_byte(state_s, data_s);
         resp_tlast  <= (state_s == S_RESP_0);
         cmd_ack_o   <= (state_r == S_DONE);
         buserr_o    <= buserr_s;
         timeout_o   <= timeout_s;
      end
   end

endmodule
